debounce_led_bar: RTL

Parametrised N-channel push-button front end and LED bar controller for the board-level LED designs. Each raw button is synchronised and debounced, and yields press, release and long-press event pulses. The events drive a saturating level register, displayed on the LED row as a bar or a single dot. The block replaces ad-hoc single-button debounce logic and adds multi-channel events, long-press detection and display modes.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_ch.sv | 83 ++++++++
 rtl/debounce_led_bar.sv | 92 +++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types, button role indices and width helper for the debounced LED bar.
package debounce_pkg;

    typedef enum logic {
        MODE_BAR = 1'b0,
        MODE_DOT = 1'b1
    } led_mode_e;

    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_DEC  = 1;
    localparam int unsigned BTN_CLR  = 2;
    localparam int unsigned BTN_MODE = 3;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, hold counter and
// registered press/release/long-press pulses.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned LONG_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic btn_state_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_W = cnt_w(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [1:0]        sync_q;
    logic              state_q, state_d;
    logic              state_prev_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Any cycle where the synchronised input agrees with the accepted state restarts the count.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = '0;
        hold_d    = '0;
        press_d   = state_q & ~state_prev_q;
        release_d = ~state_q & state_prev_q;
        long_d    = state_q && (hold_q == HOLD_LAST);

        if (sync_q[1] != state_q) begin
            if (db_cnt_q == DB_LAST) begin
                state_d = ~state_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        if (state_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state_q      <= 1'b0;
            state_prev_q <= 1'b0;
            db_cnt_q     <= '0;
            hold_q       <= '0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], button_i};
            state_q      <= state_d;
            state_prev_q <= state_q;
            db_cnt_q     <= db_cnt_d;
            hold_q       <= hold_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
        end
    end

    assign btn_state_o  = state_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/debounce_led_bar.sv
// N-channel debounced button front end driving a saturating level shown on an
// LED row as a bar or a single dot.
module debounce_led_bar
    import debounce_pkg::*;
#(
    parameter int unsigned N_BTN       = 5,
    parameter int unsigned N_LED       = 10,
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned LONG_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_BTN-1:0]          button_i,
    output logic [N_BTN-1:0]          btn_state_o,
    output logic [N_BTN-1:0]          press_o,
    output logic [N_BTN-1:0]          release_o,
    output logic [N_BTN-1:0]          long_press_o,
    output logic [cnt_w(N_LED)-1:0]   level_o,
    output logic                      mode_o,
    output logic [N_LED-1:0]          leds_o
);

    localparam int unsigned LVL_W = cnt_w(N_LED);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LED);

    logic [LVL_W-1:0] level_q, level_d;
    led_mode_e        mode_q, mode_d;
    logic [N_LED-1:0] leds_q, leds_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .button_i     (button_i[g]),
            .btn_state_o  (btn_state_o[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .long_press_o (long_press_o[g])
        );
    end

    // Level priority: long-press fill, clear, then inc/dec (which cancel when simultaneous).
    always_comb begin
        level_d = level_q;
        mode_d  = mode_q;

        if (long_press_o[BTN_INC]) begin
            level_d = LVL_MAX;
        end else if (press_o[BTN_CLR]) begin
            level_d = '0;
        end else if (press_o[BTN_INC] && !press_o[BTN_DEC]) begin
            if (level_q != LVL_MAX) level_d = level_q + LVL_W'(1);
        end else if (press_o[BTN_DEC] && !press_o[BTN_INC]) begin
            if (level_q != '0) level_d = level_q - LVL_W'(1);
        end

        if (press_o[BTN_MODE]) begin
            mode_d = (mode_q == MODE_BAR) ? MODE_DOT : MODE_BAR;
        end
    end

    always_comb begin
        leds_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (mode_q == MODE_BAR) begin
                leds_d[i] = LVL_W'(i) < level_q;
            end else begin
                leds_d[i] = LVL_W'(i + 1) == level_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            mode_q  <= MODE_BAR;
            leds_q  <= '0;
        end else begin
            level_q <= level_d;
            mode_q  <= mode_d;
            leds_q  <= leds_d;
        end
    end

    assign level_o = level_q;
    assign mode_o  = mode_q;
    assign leds_o  = leds_q;

endmodule
